lcd_nibble_writer: RTL
======================

LCD_NIBBLE_WRITER -- requirements
Module: lcd_nibble_writer

Interface
REQ-001 Parameter SETUP_CYC, default 2: clocks data/RS are held stable before oLCD_Enabled rises.
REQ-002 Parameter EN_CYC, default 12: clocks oLCD_Enabled is held high per nibble.
REQ-003 Parameter HOLD_CYC, default 1: clocks data/RS are held stable after oLCD_Enabled falls.
REQ-004 Parameter GAP_CYC, default 50: idle clocks between the upper and lower nibble.
REQ-005 Parameter WAIT_CYC, default 2000: post-byte wait clocks (40 us at 50 MHz).
REQ-006 Parameter LONG_WAIT_CYC, default 82000: post-byte wait for clear/home commands (1.64 ms).
REQ-007 Clock  in  1  system clock, 50 MHz, rising edge.
REQ-008 Reset  in  1  synchronous, active-low reset.
REQ-009 iStart  in  1  request to write one byte; sampled only while oReady=1.
REQ-010 iRS  in  1  register select for the byte (0 command, 1 data).
REQ-011 iData  in  8  byte to write.
REQ-012 oReady  out  1  high only in IDLE; block accepts iStart.
REQ-013 oDone  out  1  one-cycle pulse on byte completion.
REQ-014 oLCD_Enabled  out  1  LCD E strobe.
REQ-015 oLCD_RegisterSelect  out  1  LCD RS.
REQ-016 oLCD_StrataFlashControl  out  1  constant 1, keeps the StrataFlash off the shared bus.
REQ-017 oLCD_ReadWrite  out  1  constant 0, write only.
REQ-018 oLCD_Data  out  4  LCD DB[7:4].

Function
REQ-019 States SHALL be IDLE, HI_SETUP, HI_EN, HI_HOLD, GAP, LO_SETUP, LO_EN, LO_HOLD and WAIT, visited strictly in that order.
REQ-020 The accepting edge SHALL be a rising edge with Reset=1, state IDLE and iStart=1; on that edge iRS and iData are latched internally.
REQ-021 Changes to iData/iRS after the accepting edge SHALL have no effect on the transfer in progress.
REQ-022 The state lasts SHALL be: HI_SETUP/LO_SETUP = SETUP_CYC, HI_EN/LO_EN = EN_CYC, HI_HOLD/LO_HOLD = HOLD_CYC, GAP = GAP_CYC and WAIT = WAIT_CYC (or LONG_WAIT_CYC per REQ-036) clocks.
REQ-023 oLCD_Data SHALL equal latched data[7:4] from HI_SETUP through GAP, latched data[3:0] from LO_SETUP through WAIT, and 0 in IDLE.
REQ-024 oLCD_Enabled SHALL be 1 only in HI_EN and LO_EN.
REQ-025 oLCD_RegisterSelect SHALL equal latched RS outside IDLE and 0 in IDLE.
REQ-026 With default parameters the block SHALL be busy (oReady=0) for exactly 2080 clocks after the accepting edge.
REQ-027 oDone=1 and oReady=1 SHALL occur together in the first IDLE cycle after WAIT.
REQ-028 iStart asserted in the oDone cycle SHALL be accepted (back-to-back bytes, no extra gap).
REQ-029 iStart while oReady=0 SHALL be ignored and SHALL NOT be queued.
REQ-030 The single down-counter SHALL be 17 bits wide, reload on every state entry, and never wrap.
REQ-031 The outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-032 On a rising edge with Reset=0 the block SHALL enter IDLE and clear the counter and latched data/RS.
REQ-033 After reset, outputs SHALL be oReady=1, oDone=0, oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0, oLCD_ReadWrite=0 and oLCD_StrataFlashControl=1.
REQ-034 Reset mid-transfer, including during HI_EN/LO_EN, SHALL drop oLCD_Enabled on that same edge with no oDone pulse.

Configuration
REQ-035 The macro LCD_LONG_WAIT_EN SHALL enable the extended post-byte wait.
REQ-036 With LCD_LONG_WAIT_EN defined, a byte with RS=0 and data 0x01 or 0x02 SHALL use LONG_WAIT_CYC in WAIT (busy 82080 clocks); all other bytes use WAIT_CYC.
REQ-037 Without LCD_LONG_WAIT_EN, all bytes SHALL use WAIT_CYC, and the LONG_WAIT_CYC parameter SHALL be unused.

Verification
REQ-038 Reset low 5 clocks then high -> all outputs at REQ-033 values; oReady=1.
REQ-039 Write RS=1, data 0x41 -> DB=0x4 with E high for 12 clocks starting 2 clocks after acceptance; DB=0x1 with E high for 12 clocks starting 67 clocks after acceptance; oDone at clock 2081.
REQ-040 iStart held high continuously with data 0x38 -> transfers repeat every 2081 clocks; iStart pulses mid-transfer create no extra transfer.
REQ-041 Reset low at clock 8 of HI_EN -> E=0 on that edge, IDLE, no oDone; a following write of 0x0C completes normally.
REQ-042 With LCD_LONG_WAIT_EN, write RS=0, data 0x01 -> oDone at clock 82081; RS=1, data 0x01 -> oDone at clock 2081; without the macro both -> oDone at clock 2081.
REQ-043 Throughout all scenarios oLCD_ReadWrite=0 and oLCD_StrataFlashControl=1, and DB/RS never change while E=1.

Source files
------------

// File: rtl/lcd_nibble_writer.sv
// Writes one byte to a 4-bit HD44780-style LCD as two timed nibbles and then waits out the command time.
// Defining LCD_LONG_WAIT_EN gives clear/home commands (RS=0, data 0x01/0x02) the LONG_WAIT_CYC wait.
module lcd_nibble_writer #(
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 12,
  parameter int HOLD_CYC      = 1,
  parameter int GAP_CYC       = 50,
  parameter int WAIT_CYC      = 2000,
  parameter int LONG_WAIT_CYC = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_StrataFlashControl,
  output logic       oLCD_ReadWrite,
  output logic [3:0] oLCD_Data
);

  localparam int CNT_W = 17;

  // Counter holds remaining cycles minus one; every duration must be at least 1.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, HI_SETUP, HI_EN, HI_HOLD, GAP, LO_SETUP, LO_EN, LO_HOLD, WAIT
  } state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [7:0]       dataQ, dataNext;
  logic             rsQ, rsNext;
  logic [CNT_W-1:0] waitLoad;
  logic             readyNext, doneNext, enNext, rsOutNext;
  logic [3:0]       dbNext;

`ifdef LCD_LONG_WAIT_EN
  localparam logic [CNT_W-1:0] LONG_LD = CNT_W'(LONG_WAIT_CYC - 1);
  assign waitLoad = (!rsQ && (dataQ == 8'h01 || dataQ == 8'h02)) ? LONG_LD : WAIT_LD;
`else
  // The long wait has no effect in this build.
  logic unusedLongWait;
  assign unusedLongWait = |LONG_WAIT_CYC;
  assign waitLoad = WAIT_LD;
`endif

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    dataNext  = dataQ;
    rsNext    = rsQ;
    if (state == IDLE) begin
      cntNext = '0;
      if (iStart) begin
        nextState = HI_SETUP;
        cntNext   = SETUP_LD;
        dataNext  = iData;
        rsNext    = iRS;
      end
    end else if (cnt != '0) begin
      cntNext = cnt - CNT_W'(1);
    end else begin
      unique case (state)
        HI_SETUP: begin nextState = HI_EN;    cntNext = EN_LD;    end
        HI_EN:    begin nextState = HI_HOLD;  cntNext = HOLD_LD;  end
        HI_HOLD:  begin nextState = GAP;      cntNext = GAP_LD;   end
        GAP:      begin nextState = LO_SETUP; cntNext = SETUP_LD; end
        LO_SETUP: begin nextState = LO_EN;    cntNext = EN_LD;    end
        LO_EN:    begin nextState = LO_HOLD;  cntNext = HOLD_LD;  end
        LO_HOLD:  begin nextState = WAIT;     cntNext = waitLoad; end
        WAIT:     begin nextState = IDLE;     cntNext = '0;       end
        default:  begin nextState = IDLE;     cntNext = '0;       end
      endcase
    end
  end

  // Outputs are registered from the next-state view so they line up with the state register.
  always_comb begin
    readyNext = (nextState == IDLE);
    doneNext  = (state == WAIT) && (nextState == IDLE);
    enNext    = (nextState == HI_EN) || (nextState == LO_EN);
    rsOutNext = (nextState == IDLE) ? 1'b0 : rsNext;
    dbNext    = 4'h0;
    unique case (nextState)
      IDLE:                         dbNext = 4'h0;
      HI_SETUP, HI_EN, HI_HOLD, GAP: dbNext = dataNext[7:4];
      default:                      dbNext = dataNext[3:0];
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      dataQ               <= '0;
      rsQ                 <= 1'b0;
      oReady              <= 1'b1;
      oDone               <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= 4'h0;
    end else begin
      state               <= nextState;
      cnt                 <= cntNext;
      dataQ               <= dataNext;
      rsQ                 <= rsNext;
      oReady              <= readyNext;
      oDone               <= doneNext;
      oLCD_Enabled        <= enNext;
      oLCD_RegisterSelect <= rsOutNext;
      oLCD_Data           <= dbNext;
    end
  end

  assign oLCD_StrataFlashControl = 1'b1;
  assign oLCD_ReadWrite          = 1'b0;

endmodule
